// File: rtl/uart_line_status_pkg.sv
// Shared UART definitions: LSR bit positions and reset image, used by the line-status stage and the register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_line_status_pkg;

    localparam int LSR_DR      = 0;
    localparam int LSR_OE      = 1;
    localparam int LSR_PE      = 2;
    localparam int LSR_FE      = 3;
    localparam int LSR_BI      = 4;
    localparam int LSR_THRE    = 5;
    localparam int LSR_TEMT    = 6;
    localparam int LSR_FIFOERR = 7;

    // THRE and TEMT come up set: nothing is queued or shifting after reset.
    localparam logic [7:0] LSR_RESET = 8'h60;

    // Line error summary seen by the interrupt controller (OE, PE, FE, BI).
    function automatic logic lsr_error(input logic [7:0] lsr_img);
        return lsr_img[LSR_OE] | lsr_img[LSR_PE] | lsr_img[LSR_FE] | lsr_img[LSR_BI];
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// RX character timeout: counts baud ticks while RX data sits untouched and flags idle beyond TO_CHARS chars.
// Latency: 1 cycle from push/pop/tick to rx_timeout.
// Backpressure: none; strobes are accepted every cycle.
module uart_rx_timeout #(
    parameter int TO_CHARS = 4,
    parameter int TICK_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_push,
    input  logic        rx_pop,
    input  logic        rx_count_nz,
    input  logic        baud_tick,
    input  logic [9:0]  char_ticks,
    output logic        rx_timeout
);

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [TICK_W-1:0] threshold;

    // char_ticks is used live, so a mid-count change only moves the threshold.
    assign threshold = TICK_W'(TO_CHARS) * TICK_W'(char_ticks);

    // Any FIFO activity or an empty FIFO restarts the idle count; otherwise count ticks, saturating.
    always_comb begin
        tick_next = tick_cnt;
        if (rx_push || rx_pop || !rx_count_nz) begin
            tick_next = '0;
        end else if (baud_tick && (tick_cnt != '1)) begin
            tick_next = tick_cnt + TICK_W'(1);
        end
    end

    // Compare against the next count so the flag drops the cycle after a push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            tick_cnt   <= tick_next;
            rx_timeout <= rx_count_nz && (tick_next >= threshold);
        end
    end

endmodule

// File: rtl/uart_line_status.sv
// UART line-status stage: builds the LSR image (sticky errors, FIFO error count, TX empties) and RX timeout.
// Latency: 1 cycle from any input event to the registered LSR / flag outputs.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
module uart_line_status
    import uart_line_status_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int TO_CHARS = 4,
    parameter int TICK_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_push,
    input  logic             rx_pe,
    input  logic             rx_fe,
    input  logic             rx_bi,
    input  logic             rx_drop,
    input  logic             rx_pop,
    input  logic             rx_pop_err,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             tx_fifo_empty,
    input  logic             tx_idle,
    input  logic             lsr_rd,
    input  logic             baud_tick,
    input  logic [9:0]       char_ticks,
    output logic [7:0]       lsr,
    output logic             error,
    output logic             rx_data_ready,
    output logic             tx_data_empty,
    output logic             rx_timeout
);

    logic             dr_q, oe_q, pe_q, fe_q, bi_q, thre_q, temt_q, fifo_err_q;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_cnt_next;
    logic             err_inc;
    logic             err_dec;
    logic             rx_count_nz;

    assign rx_count_nz = (rx_count != '0);
    assign err_inc     = rx_push & (rx_pe | rx_fe | rx_bi);
    assign err_dec     = rx_pop & rx_pop_err;

    // Count of flagged chars still in the RX FIFO; push+pop together cancel, saturates at both ends.
    always_comb begin
        err_cnt_next = err_cnt;
        if (err_inc && !err_dec && (err_cnt != '1)) begin
            err_cnt_next = err_cnt + CNT_W'(1);
        end else if (err_dec && !err_inc && (err_cnt != '0)) begin
            err_cnt_next = err_cnt - CNT_W'(1);
        end
    end

    // LSR bits: level bits follow their sources, error bits are sticky until an LSR read (a new set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_q       <= LSR_RESET[LSR_DR];
            oe_q       <= LSR_RESET[LSR_OE];
            pe_q       <= LSR_RESET[LSR_PE];
            fe_q       <= LSR_RESET[LSR_FE];
            bi_q       <= LSR_RESET[LSR_BI];
            thre_q     <= LSR_RESET[LSR_THRE];
            temt_q     <= LSR_RESET[LSR_TEMT];
            fifo_err_q <= LSR_RESET[LSR_FIFOERR];
            err_cnt    <= '0;
        end else begin
            dr_q       <= rx_count_nz;
            oe_q       <= (oe_q & ~lsr_rd) | rx_drop;
            pe_q       <= (pe_q & ~lsr_rd) | (rx_push & rx_pe);
            fe_q       <= (fe_q & ~lsr_rd) | (rx_push & rx_fe);
            bi_q       <= (bi_q & ~lsr_rd) | (rx_push & rx_bi);
            thre_q     <= tx_fifo_empty;
            temt_q     <= tx_fifo_empty & tx_idle;
            fifo_err_q <= (err_cnt_next != '0);
            err_cnt    <= err_cnt_next;
        end
    end

    uart_rx_timeout #(
        .TO_CHARS (TO_CHARS),
        .TICK_W   (TICK_W)
    ) u_rx_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_push     (rx_push),
        .rx_pop      (rx_pop),
        .rx_count_nz (rx_count_nz),
        .baud_tick   (baud_tick),
        .char_ticks  (char_ticks),
        .rx_timeout  (rx_timeout)
    );

    assign lsr           = {fifo_err_q, temt_q, thre_q, bi_q, fe_q, pe_q, oe_q, dr_q};
    assign error         = lsr_error(lsr);
    assign rx_data_ready = lsr[LSR_DR];
    assign tx_data_empty = lsr[LSR_THRE];

endmodule
